// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes and status flags.
// Single-cycle ops register their result on the accept edge. MUL/DIV/REM
// iterate one bit per cycle in CALC, sharing one hi/lo register pair.
module alu_seq #(
   parameter int WIDTH     = 16,
   parameter bit MULDIV_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [WIDTH-1:0] immediate,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             div_zero,
   output logic             illegal,
   output logic             busy
);
   localparam int SW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state;

   // Iterative datapath: hi = partial product high half / remainder,
   // lo = multiplier being consumed / quotient being built, opb = src2.
   logic [WIDTH-1:0] hi, lo, opb;
   logic             is_mul, is_rem;
   logic [SW-1:0]    cnt;

   logic accept;
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   // Single-cycle result/flags and iterative-op detection from live inputs
   logic [WIDTH:0]   sum_w;
   logic [WIDTH-1:0] dif_w, res_n;
   logic             c_n, v_n, dz_n, il_n, iter_n;
   logic [SW-1:0]    amt;
   assign sum_w = {1'b0, src1} + {1'b0, src2};
   assign dif_w = src1 - src2;
   assign amt   = src2[SW-1:0];

   always_comb begin
      res_n  = '0;
      c_n    = 1'b0;
      v_n    = 1'b0;
      dz_n   = 1'b0;
      il_n   = 1'b0;
      iter_n = 1'b0;
      case (opcode)
         4'h0: begin
            res_n = sum_w[WIDTH-1:0];
            c_n   = sum_w[WIDTH];
            v_n   = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum_w[WIDTH-1] != src1[WIDTH-1]);
         end
         4'h1: begin
            res_n = dif_w;
            c_n   = (src1 < src2);
            v_n   = (src1[WIDTH-1] != src2[WIDTH-1]) && (dif_w[WIDTH-1] != src1[WIDTH-1]);
         end
         4'h2, 4'h3, 4'hC: begin
            if (!MULDIV_EN)                        il_n   = 1'b1;
            else if (opcode != 4'h2 && src2 == '0) dz_n   = 1'b1;
            else                                   iter_n = 1'b1;
         end
         4'h4: res_n = src1 & src2;
         4'h5: res_n = src1 | src2;
         4'h6: res_n = src1 ^ src2;
         4'h7: res_n = ~src1;
         4'h8: res_n = immediate;
         4'h9: res_n = src1 << amt;
         4'hA: res_n = src1 >> amt;
         4'hB: res_n = WIDTH'($signed(src1) >>> amt);
         default: il_n = 1'b1;
      endcase
   end

   // One step of shift-add multiply or restoring divide
   logic [WIDTH:0]   madd, dsh, ddif;
   logic             dge;
   logic [WIDTH-1:0] hi_s, lo_s, res_f;
   assign madd = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
   assign dsh  = {hi, lo[WIDTH-1]};
   assign ddif = dsh - {1'b0, opb};
   assign dge  = (dsh >= {1'b0, opb});

   always_comb begin
      if (is_mul) begin
         hi_s = madd[WIDTH:1];
         lo_s = {madd[0], lo[WIDTH-1:1]};
      end else begin
         hi_s = dge ? ddif[WIDTH-1:0] : dsh[WIDTH-1:0];
         lo_s = {lo[WIDTH-2:0], dge};
      end
      res_f = (!is_mul && is_rem) ? hi_s : lo_s;
   end

   // Control FSM with registered result, flags, out_valid and busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         div_zero  <= 1'b0;
         illegal   <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         opb       <= '0;
         is_mul    <= 1'b0;
         is_rem    <= 1'b0;
         cnt       <= '0;
      end else if (accept) begin
         if (iter_n) begin
            state     <= CALC;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= src1;
            opb       <= src2;
            is_mul    <= (opcode == 4'h2);
            is_rem    <= (opcode == 4'hC);
            cnt       <= '0;
         end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= res_n;
            carry_out <= c_n;
            overflow  <= v_n;
            zero      <= (res_n == '0);
            negative  <= res_n[WIDTH-1];
            div_zero  <= dz_n;
            illegal   <= il_n;
         end
      end else if (state == CALC) begin
         hi  <= hi_s;
         lo  <= lo_s;
         cnt <= cnt + 1'b1;
         if (cnt == '1) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= res_f;
            carry_out <= is_mul && (hi_s != '0);
            overflow  <= 1'b0;
            zero      <= (res_f == '0);
            negative  <= res_f[WIDTH-1];
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
         end
      end else if (state == DONE && out_ready) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + random stimulus, scoreboard queue filled by the
// driver on each accept, drained and compared by an independent monitor.
module tb_alu_seq;
   localparam int W = 16;

   logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]    opcode;
   logic [W-1:0]  src1, src2, immediate, result;
   logic          carry_out, overflow, zero, negative, div_zero, illegal, busy;

   alu_seq #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .src1(src1), .src2(src2), .immediate(immediate),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .carry_out(carry_out), .overflow(overflow), .zero(zero), .negative(negative),
      .div_zero(div_zero), .illegal(illegal), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {result, carry, overflow, zero, negative, div_zero, illegal}
   typedef logic [W+5:0] resp_t;
   resp_t q[$];
   int    n_pass = 0, n_total = 0;
   bit    rnd_rdy = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // Reference model: plain integer arithmetic on the opcode table
   function automatic resp_t model(input logic [3:0] op, input logic [W-1:0] a, b, imm);
      int unsigned ua = a, ub = b, p;
      int          sa = $signed(a);
      logic [W-1:0] r = '0;
      logic c = 0, v = 0, dz = 0, il = 0;
      case (op)
         0: begin p = ua + ub; r = W'(p); c = (p > 32'hFFFF);
                  v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
         1: begin r = W'(ua - ub); c = (ua < ub);
                  v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
         2: begin p = ua * ub; r = W'(p); c = (p >= 32'h10000); end
         3: if (ub == 0) dz = 1; else r = W'(ua / ub);
         12: if (ub == 0) dz = 1; else r = W'(ua % ub);
         4: r = a & b;
         5: r = a | b;
         6: r = a ^ b;
         7: r = ~a;
         8: r = imm;
         9: r = W'(ua << b[3:0]);
         10: r = W'(ua >> b[3:0]);
         11: r = W'(sa >>> b[3:0]);
         default: il = 1;
      endcase
      return {r, c, v, (r == 0), r[W-1], dz, il};
   endfunction

   resp_t cur, held;
   bit    hold_v = 0;
   assign cur = {result, carry_out, overflow, zero, negative, div_zero, illegal};

   // Monitor: result stability while stalled, scoreboard compare on handshake
   always @(negedge clk) begin
      if (!rst_n) hold_v = 0;
      else begin
         if (hold_v && out_valid) chk("stall_stable", 32'(cur), 32'(held));
         hold_v = out_valid && !out_ready;
         held   = cur;
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out_valid", 1, 0);
            else chk("result_flags", 32'(cur), 32'(q.pop_front()));
         end
      end
   end

   // Random backpressure when enabled
   always begin
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Present an op and hold it until accepted; returns 1 time unit after the accept edge
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, imm);
      bit acc = 0;
      int n = 0;
      opcode = op; src1 = a; src2 = b; immediate = imm; in_valid = 1;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) q.push_back(model(op, a, b, imm));
         @(posedge clk); #1;
         if (++n > 200) begin chk("accept_timeout", 0, 1); break; end
      end
      in_valid = 0;
      src1 = W'($urandom); src2 = W'($urandom); immediate = W'($urandom);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int k, bcnt;
      logic [3:0] op;
      logic [W-1:0] a, b;
      rst_n = 0; in_valid = 0; out_ready = 1; opcode = 0;
      src1 = 0; src2 = 0; immediate = 0;
      cycles(3);
      chk("reset_outputs", 32'({out_valid, busy, cur}), 0);
      chk("reset_in_ready", 32'(in_ready), 1);
      rst_n = 1;
      cycles(2);

      // ADD wrap: 1-cycle latency
      issue(4'h0, 16'hFFFF, 16'h0001, 0);
      chk("add_latency", 32'(out_valid), 1);
      chk("add_flags", 32'({result, carry_out, zero, overflow}), 32'({16'h0, 3'b110}));
      issue(4'h1, 16'h8000, 16'h0001, 0);
      issue(4'h1, 16'h0003, 16'h0005, 0);
      chk("sub_neg", 32'({result, carry_out, negative}), 32'({16'hFFFE, 2'b11}));

      // MUL latency and busy duration
      issue(4'h2, 16'h0100, 16'h0100, 0);
      k = 0; bcnt = 0;
      while (!out_valid && k < 40) begin
         if (busy) bcnt++;
         cycles(1); k++;
      end
      chk("mul_latency", k, 16);
      chk("mul_busy_cycles", bcnt, 16);
      chk("mul_result", 32'({result, carry_out}), 32'({16'h0, 1'b1}));
      cycles(1);
      issue(4'h3, 16'd100, 16'd7, 0);
      cycles(17);
      chk("div_100_7", 32'(result), 14);
      issue(4'hC, 16'd100, 16'd7, 0);
      cycles(17);
      chk("rem_100_7", 32'(result), 2);

      // Divide by zero: no CALC
      issue(4'h3, 16'h1234, 16'h0000, 0);
      chk("div0_no_busy", 32'({busy, out_valid, div_zero}), 32'(3'b011));
      issue(4'hE, 16'h1234, 16'h5678, 0);
      chk("illegal_op", 32'({result, illegal}), 32'({16'h0, 1'b1}));
      cycles(2);

      // Stall: hold ADD for 5 cycles, release with an XOR pending
      out_ready = 0;
      issue(4'h0, 16'h1234, 16'h1111, 0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", 32'(in_ready), 0);
         cycles(1);
      end
      out_ready = 1;
      issue(4'h6, 16'hF0F0, 16'h0FF0, 0);
      chk("xor_follows", 32'({out_valid, result}), 32'({1'b1, 16'hFF00}));
      cycles(2);

      // Reset 5 cycles into a MUL
      issue(4'h2, 16'h1234, 16'h0055, 0);
      cycles(5);
      #2 rst_n = 0;
      #1;
      q.delete();
      chk("async_reset_outputs", 32'({out_valid, busy, cur}), 0);
      chk("async_reset_in_ready", 32'(in_ready), 1);
      cycles(5);
      rst_n = 1;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid || busy) k++;
         cycles(1);
      end
      chk("no_stale_out_valid", k, 0);

      // Random ops with random backpressure and idle gaps
      rnd_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = W'($urandom);
         b  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
         if ($urandom_range(0, 3) == 0) b = W'(b & 16'h00FF);
         issue(op, a, b, W'($urandom));
         if ($urandom_range(0, 4) == 0) cycles($urandom_range(1, 3));
      end
      rnd_rdy = 0;
      cycles(1);
      out_ready = 1;
      k = 0;
      while (q.size() != 0 && k < 100) begin cycles(1); k++; end
      chk("drain_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
